poly_horner_ctrl: RTL and testbench

- Sequencing controller for the polynomial evaluator's Horner datapath.
- Accepts an evaluation request with a polynomial degree N over a ready/start handshake.
- Walks a down-counting coefficient index from N to 0 and drives the coefficient-memory address plus the accumulator load and multiply-accumulate strobes.
- Respects the multiply-accumulate pipeline latency, then pulses done when acc = (...(c_N*x + c_(N-1))*x + ...) + c_0 is valid.

---
 rtl/poly_horner_ctrl.sv | 108 ++++++++++
 tb/tb_poly_horner_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_horner_ctrl.sv
// Sequencer for the Horner polynomial datapath: walks coefficient addresses N..0
// and issues acc_load / mac_en strobes spaced by the multiply-accumulate latency.
module poly_horner_ctrl #(
  parameter int DEG_W   = 4,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DEG_W-1:0] degree,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic [DEG_W-1:0] coef_addr,
  output logic             acc_load,
  output logic             mac_en,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  // MAC already spends one cycle of the latency, WAIT's zero-count cycle another.
  localparam logic [3:0] WAIT_INIT = (MAC_LAT >= 2) ? 4'(MAC_LAT - 2) : 4'd0;

  state_t           state_reg, state_next;
  logic [DEG_W-1:0] idx_reg, idx_next;
  logic [DEG_W-1:0] addr_reg, addr_next;
  logic [3:0]       wait_reg, wait_next;
  logic             step_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      addr_reg  <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    wait_next  = wait_reg;
    step_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          idx_next   = degree;
          addr_next  = degree;
          state_next = LOAD;
        end
      end
      LOAD: step_next = 1'b1;
      MAC: begin
        if (MAC_LAT == 1) begin
          step_next = 1'b1;
        end else begin
          wait_next  = WAIT_INIT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_reg != 4'd0) wait_next = wait_reg - 4'd1;
        else                  step_next = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Shared exit: finish at index 0, otherwise step to the next lower coefficient.
    if (step_next) begin
      if (idx_reg == '0) begin
        state_next = DONE;
      end else begin
        idx_next   = idx_reg - 1'b1;
        addr_next  = idx_reg - 1'b1;
        state_next = MAC;
      end
    end

    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      idx_next   = idx_reg;
      addr_next  = addr_reg;
    end
  end

  assign ready     = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign acc_load  = (state_reg == LOAD);
  assign mac_en    = (state_reg == MAC);
  assign done      = (state_reg == DONE);
  assign coef_addr = addr_reg;

endmodule

// File: tb/tb_poly_horner_ctrl.sv
// Scoreboard bench: expected strobe events and results are queued at accept time
// and popped as the selected controller instance produces them.
module tb_poly_horner_ctrl;

  localparam int NI = 4;

  typedef struct {
    int kind;   // 0 = acc_load, 1 = mac_en, 2 = done
    int cyc;
    int addr;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_a  [NI];
  logic [3:0] degree_a [NI];
  logic       abort_a  [NI];
  logic       rdy_a [NI];
  logic       bsy_a [NI];
  logic [3:0] addr_a[NI];
  logic       ld_a  [NI];
  logic       me_a  [NI];
  logic       dn_a  [NI];

  int lats[NI] = '{2, 1, 3, 7};

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      poly_horner_ctrl #(
        .DEG_W  (4),
        .MAC_LAT(gi == 0 ? 2 : gi == 1 ? 1 : gi == 2 ? 3 : 7)
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start_a[gi]),
        .degree   (degree_a[gi]),
        .abort    (abort_a[gi]),
        .ready    (rdy_a[gi]),
        .busy     (bsy_a[gi]),
        .coef_addr(addr_a[gi]),
        .acc_load (ld_a[gi]),
        .mac_en   (me_a[gi]),
        .done     (dn_a[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int         sel = 0;
  logic       s_ready, s_busy, s_ld, s_me, s_dn;
  logic [3:0] s_addr;

  always_comb begin
    s_ready = rdy_a[sel];
    s_busy  = bsy_a[sel];
    s_ld    = ld_a[sel];
    s_me    = me_a[sel];
    s_dn    = dn_a[sel];
    s_addr  = addr_a[sel];
  end

  int     n_tests = 0;
  int     n_fail  = 0;
  int     tick    = 0;
  int     t0      = 0;
  bit     mon_en  = 1'b0;
  longint coef[16];
  longint x = 0;
  longint acc = 0;
  ev_t    exp_q[$];
  longint res_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Datapath model driven by the strobes of the selected instance.
  always @(posedge clk) begin
    tick <= tick + 1;
    if (s_ld)      acc <= coef[s_addr];
    else if (s_me) acc <= acc * x + coef[s_addr];
  end

  always @(negedge clk) begin
    if (mon_en) begin
      int  rel;
      int  kind;
      ev_t e;
      rel = tick - t0;
      check("ready_xor_busy", longint'(s_ready ^ s_busy), 1);
      check("strobe_excl", longint'((32'(s_ld) + 32'(s_me) + 32'(s_dn)) <= 1), 1);
      if (s_ld || s_me || s_dn) begin
        kind = s_ld ? 0 : (s_me ? 1 : 2);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", kind, -1);
        end else begin
          e = exp_q.pop_front();
          check("ev_kind", kind, e.kind);
          check("ev_cycle", rel, e.cyc);
          check("ev_addr", longint'(s_addr), e.addr);
        end
      end
      if (s_dn) begin
        if (res_q.size() == 0) check("unexpected_done", 1, 0);
        else                   check("result", acc, res_q.pop_front());
      end
    end
  end

  function automatic longint poly_val(input int n);
    longint s = 0;
    longint pw = 1;
    for (int i = 0; i <= n; i++) begin
      s += coef[i] * pw;
      pw *= x;
    end
    return s;
  endfunction

  // Accept a request on instance inst; queue expected events up to cycle 'limit'.
  task automatic start_run(input int inst, input int n, input int limit);
    int  l;
    ev_t e;
    l = lats[inst];
    sel = inst;
    degree_a[inst] = 4'(n);
    start_a[inst] = 1'b1;
    t0 = tick;
    e = '{0, 1, n};
    if (e.cyc <= limit) exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      e = '{1, 2 + k * l, n - 1 - k};
      if (e.cyc <= limit) exp_q.push_back(e);
    end
    e = '{2, 2 + n * l, 0};
    if (e.cyc <= limit) begin
      exp_q.push_back(e);
      res_q.push_back(poly_val(n));
    end
    @(negedge clk);
    start_a[inst] = 1'b0;
  endtask

  task automatic wait_ready(input int exp_rel);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 300);
    check("ready_cycle", tick - t0, exp_rel);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic full_run(input int inst, input int n);
    start_run(inst, n, 1 << 20);
    wait_ready(3 + n * lats[inst]);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_a[i] = 1'b0;
      degree_a[i] = 4'd0;
      abort_a[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) coef[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", s_ready, 1);
    check("rst_busy", s_busy, 0);
    check("rst_addr", s_addr, 0);
    check("rst_strobes", {s_ld, s_me, s_dn}, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Worked example: c = {1,2,3,4}, x = 2 -> 49.
    coef[0] = 1; coef[1] = 2; coef[2] = 3; coef[3] = 4; x = 2;
    check("example_value", poly_val(3), 49);
    full_run(0, 3);

    full_run(0, 0);
    for (int i = 0; i < 16; i++) coef[i] = longint'(i % 5);
    x = 1;
    full_run(1, 15);

    // Abort in the second WAIT of a degree-5 run.
    start_run(0, 5, 4);
    while (tick - t0 < 5) @(negedge clk);
    abort_a[0] = 1'b1;
    @(negedge clk);
    abort_a[0] = 1'b0;
    check("abort_rel", tick - t0, 6);
    check("abort_ready", s_ready, 1);
    check("abort_queue", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    x = 3;
    full_run(0, 2);

    // start pulsed while busy must neither restart nor resample degree.
    start_run(0, 4, 1 << 20);
    while (tick - t0 < 10) begin
      start_a[0] = 1'b1;
      degree_a[0] = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    start_a[0] = 1'b0;
    wait_ready(11);

    // start with abort in IDLE is never accepted.
    start_a[0] = 1'b1;
    abort_a[0] = 1'b1;
    degree_a[0] = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_abort_ready", s_ready, 1);
    end
    start_a[0] = 1'b0;
    abort_a[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset between edges while in MAC.
    start_run(0, 3, 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_ready", s_ready, 1);
    check("arst_busy", s_busy, 0);
    check("arst_mac", s_me, 0);
    check("arst_addr", s_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("arst_queue", exp_q.size(), 0);
    @(negedge clk);
    full_run(0, 1);

    // Randomised degree and latency.
    for (int r = 0; r < 14; r++) begin
      int inst;
      int n;
      inst = int'($urandom_range(0, NI - 1));
      n = int'($urandom_range(0, 15));
      x = longint'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) coef[i] = longint'($urandom_range(0, 15));
      full_run(inst, n);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
